// File: rtl/adder_pkg.sv
// Shared types for the adder stream arbiter: beat layout and FSM encoding.
// No logic; no latency; no backpressure.
package adder_pkg;

    localparam int DATAW = 128;

    typedef struct packed {
        logic [DATAW-1:0] tdata;
        logic             tlast;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/adder_stream_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit at or after rr_ptr, wrapping.
// Purely combinational; no backpressure.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Scan from the farthest offset down so the closest hit to rr_ptr wins.
    always_comb begin
        int k;
        k   = 0;
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % N;
            if (req[IW'(k)]) begin
                idx = IW'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding the adder through a one-entry output slot.
// Latency: 1 arbitration cycle, then beats appear on the adder one cycle after acceptance.
// Backpressure: granted ready = slot empty or adder ready; all other readies held low.
module adder_stream_arbiter
    import adder_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATAW   = adder_pkg::DATAW,
    parameter int CNTW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         s_axis_tvalid,
    input  logic [NUM_REQ-1:0]         s_axis_tlast,
    input  logic [NUM_REQ*DATAW-1:0]   s_axis_tdata,
    output logic [NUM_REQ-1:0]         s_axis_tready,
    output logic                       axis_adder_interface_tvalid,
    output logic                       axis_adder_interface_tlast,
    output logic [DATAW-1:0]           axis_adder_interface_tdata,
    input  logic                       axis_adder_interface_tready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [CNTW-1:0]            pkt_count,
    output logic [CNTW-1:0]            beat_count
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t       state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             slot_vld;
    logic             slot_last;
    logic [DATAW-1:0] slot_dat;
    logic             slot_free;
    logic             in_vld;
    logic             in_last;
    logic [DATAW-1:0] in_dat;
    logic             accept;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (s_axis_tvalid),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign slot_free = !slot_vld || axis_adder_interface_tready;
    assign in_vld    = s_axis_tvalid[grant_id];
    assign in_last   = s_axis_tlast[grant_id];
    assign in_dat    = s_axis_tdata[int'(grant_id)*DATAW +: DATAW];
    assign accept    = (state == BUSY) && slot_free && in_vld;

    always_comb begin
        s_axis_tready = '0;
        if ((state == BUSY) && slot_free) begin
            s_axis_tready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = BUSY;
            BUSY:    if (accept && in_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            slot_vld   <= 1'b0;
            slot_last  <= 1'b0;
            slot_dat   <= '0;
            pkt_count  <= '0;
            beat_count <= '0;
        end else begin
            if ((state == IDLE) && pick_any) begin
                grant_id   <= pick_idx;
                beat_count <= '0;
            end
            if (accept) begin
                slot_vld  <= 1'b1;
                slot_last <= in_last;
                slot_dat  <= in_dat;
                if (beat_count != '1) beat_count <= beat_count + 1'b1;
                if (in_last) begin
                    pkt_count <= pkt_count + 1'b1;
                    rr_ptr    <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end else if (axis_adder_interface_tready) begin
                slot_vld <= 1'b0;
            end
        end
    end

    assign axis_adder_interface_tvalid = slot_vld;
    assign axis_adder_interface_tlast  = slot_last;
    assign axis_adder_interface_tdata  = slot_dat;
    assign busy                        = (state == BUSY);

endmodule
